ysyx_25040109_dsram: RTL
========================

YSYX_25040109_DSRAM -- requirements
Module: ysyx_25040109_DSRAM

Interface
REQ-001 SHALL have parameters (name, default, meaning): BASE, 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter AW, 10, word-index width; the array holds 2^AW 32-bit words.
REQ-003 SHALL have parameter DELAY, 2, fixed wait cycles (0..7) used when RAND=0.
REQ-004 SHALL have parameter RAND, 0, where 1 selects the LFSR-derived wait instead of DELAY.
REQ-005 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-low (0 = reset).
- dmem_arvalid  in  1  read address valid.
- dmem_arready  out  1  read address ready.
- dmem_araddr  in  32  read byte address.
- dmem_rvalid  out  1  read data valid.
- dmem_rready  in  1  read data ready.
- dmem_rdata  out  32  read word.
- dmem_awvalid  in  1  write address valid.
- dmem_awready  out  1  write address ready.
- dmem_awaddr  in  32  write byte address.
- dmem_wvalid  in  1  write data valid.
- dmem_wready  out  1  write data ready.
- dmem_wen  in  1  write enable; a write commits only if wen=1.
- dmem_wdata  in  32  write word, byte lanes unshifted.
- dmem_wmask  in  4  byte-lane enables, bit i = byte i.
- err  out  1  one-cycle pulse on completion of an out-of-range access.

Function
REQ-006 SHALL be the data-memory slave that sits downstream of the LSU dmem port and serves one transaction at a time.
REQ-007 SHALL implement four states: IDLE, R_WAIT, W_ADDR_DONE and W_WAIT.
REQ-008 SHALL drive dmem_arready = (state==IDLE).
REQ-009 SHALL drive dmem_awready = (state==IDLE && !dmem_arvalid), so a read wins when AR and AW are asserted in the same cycle.
REQ-010 On AR fire, SHALL latch araddr into addr_q, load cnt with the wait value, and go to R_WAIT.
REQ-011 In R_WAIT, SHALL decrement cnt each cycle while cnt!=0.
REQ-012 SHALL drive dmem_rvalid = (state==R_WAIT && cnt==0).
REQ-013 With fixed wait D, an AR fire in cycle t SHALL give rvalid first high in cycle t+1+D.
REQ-014 While rvalid=1, rdata SHALL equal mem[idx(addr_q)], or 0 if out of range, and rvalid and rdata SHALL hold stable until rready=1.
REQ-015 On R fire, SHALL return to IDLE, so a new AR can be accepted in the next cycle.
REQ-016 On AW fire, SHALL latch awaddr into addr_q, load cnt with the wait value, and go to W_WAIT.
REQ-017 SHALL drive dmem_wready = (state==W_WAIT && cnt==0), with cnt decrementing as for reads.
REQ-018 On W fire with wen=1 and an in-range address, SHALL write each byte i with wmask[i]=1 from wdata[8i+7:8i] and leave the other bytes unchanged.
REQ-019 On W fire, SHALL return to IDLE.
REQ-020 W fire with wen=0 or wmask=0 SHALL complete the handshake without modifying memory.
REQ-021 SHALL compute idx(a) = (a-BASE)>>2.
REQ-022 An address is in range iff a>=BASE and (a-BASE)<(4<<AW).
REQ-023 SHALL ignore address bits [1:0] for array indexing.
REQ-024 An out-of-range read SHALL still handshake with rdata=0.
REQ-025 An out-of-range write SHALL still handshake and drop the data.
REQ-026 On out-of-range access, err SHALL pulse high for one cycle in the cycle after the R or W fire.
REQ-027 SHALL hold an 8-bit LFSR (taps 8,6,5,4, shift left) that advances every cycle.
REQ-028 With RAND=1, the wait value SHALL be lfsr[2:0] sampled in the AR/AW fire cycle; with RAND=0 it SHALL be DELAY[2:0].
REQ-029 W_ADDR_DONE is reserved; an illegal state encoding SHALL return to IDLE in the next cycle.
REQ-030 dmem_wvalid asserted outside W_WAIT SHALL be ignored.
REQ-031 dmem_rready asserted outside R_WAIT SHALL be ignored.

Reset
REQ-032 While rst=0 at a clock edge, SHALL set state=IDLE, cnt=0, addr_q=0, err=0 and lfsr=8'h5A.
REQ-033 After reset, rvalid=0, wready=0, arready=1, awready=!arvalid and rdata=0.
REQ-034 Reset during R_WAIT or W_WAIT SHALL abort the transaction; no memory write SHALL occur in the reset cycle.
REQ-035 Array contents are not reset.

Verification
REQ-036 Fixed latency (DELAY=2): SW 0x80000010, wdata=0xDEADBEEF, wmask=4'hF, then AR 0x80000010 fire in cycle t -> rvalid first high at t+3 with rdata=0xDEADBEEF.
REQ-037 Byte mask: SW 0x80000020 <- 0x11223344, then SB-style write wdata=0x0000AA00, wmask=4'b0010 -> readback 0x1122AA44.
REQ-038 Backpressure: hold rready=0 for 5 cycles after rvalid -> rvalid and rdata stable throughout; arready=0 throughout; one R fire on release.
REQ-039 Simultaneous AR 0x80000000 and AW 0x80000004 in IDLE -> AR accepted; awready=0 until the read completes; the write completes afterwards.
REQ-040 Out of range: AR 0x00001000 -> handshake completes, rdata=0, err pulses one cycle; AW/W to 0x90000000 -> no array change, err pulse.
REQ-041 Reset mid-write: rst=0 during W_WAIT -> state IDLE next cycle, wready=0, target word unchanged; with RAND=1, the wait sequence restarts from lfsr=8'h5A.

Source files
------------

// File: rtl/ysyx_25040109_dsram.sv
// Data-memory slave for the LSU dmem port: one read or write transaction at a time,
// with a fixed or LFSR-derived wait before the data phase.
module ysyx_25040109_dsram #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned AW    = 10,
  parameter int unsigned DELAY = 2,
  parameter bit          RAND  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_arvalid,
  output logic        dmem_arready,
  input  logic [31:0] dmem_araddr,
  output logic        dmem_rvalid,
  input  logic        dmem_rready,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_awvalid,
  output logic        dmem_awready,
  input  logic [31:0] dmem_awaddr,
  input  logic        dmem_wvalid,
  output logic        dmem_wready,
  input  logic        dmem_wen,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wmask,
  output logic        err
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StRWait     = 2'd1,
    StWAddrDone = 2'd2,
    StWWait     = 2'd3
  } state_e;

  localparam logic [32:0] Limit   = 33'(4) << AW;
  localparam logic [2:0]  FixWait = DELAY[2:0];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_d;
  logic [7:0]  lfsr_q, lfsr_d;

  logic [31:0] mem [2**AW];

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [2:0]    wait_val;
  logic          ar_fire, aw_fire, r_fire, w_fire;

  assign off      = addr_q - BASE;
  assign in_range = (addr_q >= BASE) && ({1'b0, off} < Limit);
  assign idx      = off[AW+1:2];
  assign wait_val = RAND ? lfsr_q[2:0] : FixWait;

  assign dmem_arready = (state_q == StIdle);
  assign dmem_awready = (state_q == StIdle) && !dmem_arvalid;
  assign dmem_rvalid  = (state_q == StRWait) && (cnt_q == 3'd0);
  assign dmem_wready  = (state_q == StWWait) && (cnt_q == 3'd0);
  assign dmem_rdata   = (dmem_rvalid && in_range) ? mem[idx] : 32'h0;

  assign ar_fire = dmem_arvalid && dmem_arready;
  assign aw_fire = dmem_awvalid && dmem_awready;
  assign r_fire  = dmem_rvalid && dmem_rready;
  assign w_fire  = dmem_wvalid && dmem_wready;

  // x^8 + x^6 + x^5 + x^4, shifting left
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (ar_fire) begin
          addr_d  = dmem_araddr;
          cnt_d   = wait_val;
          state_d = StRWait;
        end else if (aw_fire) begin
          addr_d  = dmem_awaddr;
          cnt_d   = wait_val;
          state_d = StWWait;
        end
      end
      StRWait: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (r_fire) begin
          state_d = StIdle;
          err_d   = !in_range;
        end
      end
      StWWait: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (w_fire) begin
          state_d = StIdle;
          err_d   = !in_range;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      addr_q  <= 32'h0;
      err     <= 1'b0;
      lfsr_q  <= 8'h5A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err     <= err_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Array is not reset; a W fire coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && w_fire && dmem_wen && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wmask[i]) mem[idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

endmodule
